// File: rtl/user_flash_cache_nway_if.sv
`default_nettype none
// ============================================================================
// Module   : user_flash_cache_nway_if
// Brief    : picoRV-style select/ready read bus in front of the flash cache.
// Revision : 1.0 - initial release
// ============================================================================
interface user_flash_cache_nway_if #(
  parameter int ADDR_W = 17
);
  logic              select;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       data_o;
  logic              err;

  modport master (
    output select, wstrb, addr,
    input  ready, data_o, err
  );

  modport slave (
    input  select, wstrb, addr,
    output ready, data_o, err
  );
endinterface
`default_nettype wire

// File: rtl/user_flash_cache_nway.sv
`default_nettype none
// ============================================================================
// Module   : user_flash_cache_nway
// Brief    : N-way set-associative read cache over the Gowin user-flash array.
// Revision : 1.0 - initial release
// ============================================================================
module user_flash_cache_nway #(
  parameter int ADDR_W     = 17,
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 16,
  parameter int SE_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  user_flash_cache_nway_if.slave bus,
  input  logic                  invalidate,
  output logic                  inv_pending,
  output logic                  cache_hit,
  output logic                  cache_miss,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count,
  output logic                  flash_xe,
  output logic                  flash_ye,
  output logic                  flash_se,
  output logic [ADDR_W-9:0]     flash_xadr,
  output logic [5:0]            flash_yadr,
  input  logic [31:0]           flash_dout
);

  localparam int FA_W  = ADDR_W - 2;
  localparam int COL_W = $clog2(LINE_WORDS);
  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = FA_W - COL_W - SET_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int IDX_W = $clog2(WAYS * SETS);
  localparam int MEM_W = IDX_W + COL_W;
  localparam int CNT_W = COL_W + 1;
  localparam int SE_W  = (SE_CYCLES > 1) ? $clog2(SE_CYCLES) : 1;

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_LOAD   = 6'b000010,
    S_SELECT = 6'b000100,
    S_READ   = 6'b001000,
    S_STORE  = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  // Flat way/set index; with a single way the way bit is truncated away.
  function automatic logic [IDX_W-1:0] tidx(input logic [WAY_W-1:0] w,
                                           input logic [SET_W-1:0] s);
    return IDX_W'({w, s});
  endfunction

  state_t                r_state;
  logic [31:0]           r_data;
  logic                  r_err;
  logic                  r_inv_pending;
  logic                  r_hit;
  logic                  r_miss;
  logic [15:0]           r_hit_count;
  logic [15:0]           r_miss_count;
  logic                  r_xe;
  logic                  r_ye;
  logic                  r_se;
  logic [ADDR_W-9:0]     r_xadr;
  logic [5:0]            r_yadr;
  logic [CNT_W-1:0]      r_col;
  logic [SE_W-1:0]       r_se_cnt;
  logic [WAY_W-1:0]      r_victim;
  logic                  r_victim_is_ptr;
  logic [TAG_W-1:0]      r_tag_q;
  logic [SET_W-1:0]      r_set_q;
  logic [COL_W-1:0]      r_col_q;

  logic [WAYS*SETS-1:0]  r_valid;
  logic [TAG_W-1:0]      r_tag [WAYS*SETS];
  logic [WAY_W-1:0]      r_ptr [SETS];
  logic [31:0]           r_mem [WAYS*SETS*LINE_WORDS];

  logic [FA_W-1:0]       w_wa;
  logic [COL_W-1:0]      w_col;
  logic [SET_W-1:0]      w_set;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic                  w_has_inv;
  logic [WAY_W-1:0]      w_inv_way;
  logic [WAY_W-1:0]      w_victim;
  logic [FA_W-1:0]       w_fa;
  logic                  w_fill_done;
  logic [WAY_W-1:0]      w_ptr_next;

  assign w_wa  = bus.addr[ADDR_W-1:2];
  assign w_col = w_wa[COL_W-1:0];
  assign w_set = w_wa[COL_W+SET_W-1:COL_W];
  assign w_tag = w_wa[FA_W-1:COL_W+SET_W];
  assign w_fa  = {r_tag_q, r_set_q, r_col[COL_W-1:0]};

  assign w_fill_done = (r_state == S_LOAD) && (r_col == CNT_W'(LINE_WORDS));
  assign w_ptr_next  = (r_ptr[r_set_q] == WAY_W'(WAYS - 1)) ? '0
                                                             : r_ptr[r_set_q] + WAY_W'(1);

  // Descending scan so the lowest-index invalid way wins the victim choice.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[tidx(WAY_W'(w), w_set)]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
      if (r_valid[tidx(WAY_W'(w), w_set)] && (r_tag[tidx(WAY_W'(w), w_set)] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    w_victim = w_has_inv ? w_inv_way : r_ptr[w_set];
  end

  always_ff @(posedge clk) begin
    if (r_state == S_STORE) begin
      r_mem[{tidx(r_victim, r_set_q), r_col[COL_W-1:0]}] <= flash_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[tidx(r_victim, r_set_q)] <= r_tag_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_data          <= '0;
      r_err           <= 1'b0;
      r_inv_pending   <= 1'b0;
      r_hit           <= 1'b0;
      r_miss          <= 1'b0;
      r_hit_count     <= '0;
      r_miss_count    <= '0;
      r_xe            <= 1'b0;
      r_ye            <= 1'b0;
      r_se            <= 1'b0;
      r_xadr          <= '0;
      r_yadr          <= '0;
      r_col           <= '0;
      r_se_cnt        <= '0;
      r_victim        <= '0;
      r_victim_is_ptr <= 1'b0;
      r_tag_q         <= '0;
      r_set_q         <= '0;
      r_col_q         <= '0;
      r_valid         <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
      end
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (invalidate && (r_state != S_IDLE)) begin
        r_inv_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_inv_pending || invalidate) begin
            r_valid       <= '0;
            r_inv_pending <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
              r_ptr[s] <= '0;
            end
          end else if (bus.select) begin
            if (bus.wstrb != 4'b0000) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_hit) begin
              r_data <= r_mem[{tidx(w_hit_way, w_set), w_col}];
              r_hit  <= 1'b1;
              if (r_hit_count != 16'hFFFF) begin
                r_hit_count <= r_hit_count + 16'd1;
              end
              r_state <= S_DONE;
            end else begin
              r_miss <= 1'b1;
              if (r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
              end
              r_victim        <= w_victim;
              r_victim_is_ptr <= (w_victim == r_ptr[w_set]);
              r_tag_q         <= w_tag;
              r_set_q         <= w_set;
              r_col_q         <= w_col;
              r_col           <= '0;
              r_xe            <= 1'b1;
              r_ye            <= 1'b1;
              r_state         <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          r_xadr <= w_fa[FA_W-1:6];
          r_yadr <= w_fa[5:0];
          if (w_fill_done) begin
            r_valid[tidx(r_victim, r_set_q)] <= 1'b1;
            if (r_victim_is_ptr) begin
              r_ptr[r_set_q] <= w_ptr_next;
            end
            r_data  <= r_mem[{tidx(r_victim, r_set_q), r_col_q}];
            r_xe    <= 1'b0;
            r_ye    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_xe     <= 1'b1;
            r_ye     <= 1'b1;
            r_se     <= 1'b1;
            r_se_cnt <= '0;
            r_state  <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (r_se_cnt == SE_W'(SE_CYCLES - 1)) begin
            r_se    <= 1'b0;
            r_state <= S_READ;
          end else begin
            r_se_cnt <= r_se_cnt + SE_W'(1);
          end
        end

        // Strobes drop for the capture cycle; the array holds dout stable.
        S_READ: begin
          r_xe    <= 1'b0;
          r_ye    <= 1'b0;
          r_state <= S_STORE;
        end

        S_STORE: begin
          r_col   <= r_col + CNT_W'(1);
          r_xe    <= 1'b1;
          r_ye    <= 1'b1;
          r_state <= S_LOAD;
        end

        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready   = (r_state == S_DONE);
  assign bus.data_o  = r_data;
  assign bus.err     = r_err;
  assign inv_pending = r_inv_pending;
  assign cache_hit   = r_hit;
  assign cache_miss  = r_miss;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;
  assign flash_xe    = r_xe;
  assign flash_ye    = r_ye;
  assign flash_se    = r_se;
  assign flash_xadr  = r_xadr;
  assign flash_yadr  = r_yadr;

endmodule
`default_nettype wire
